// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - parametrised universal shift register with counted shift
//
// Purpose: N-bit register with synchronous clear, parallel load, single-step
// shift and a counted multi-bit shift driven by an internal down-counter.
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-high reset
//   sclr     synchronous clear (also aborts a counted shift)
//   load     parallel load of data_in (idle only)
//   data_in  parallel load value
//   shift_s  single-step shift using mode (idle only)
//   ser_in   serial fill bit for the logical modes
//   mode     00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left
//   start    begin a counted shift of amount positions
//   amount   counted shift length
//   data_out register contents
//   ser_out  bit the next shift expels under the effective mode
//   busy     counted shift in progress
//   done     one-cycle pulse when a counted shift completes
//
// Configuration macro: USR_ROTATE_EN - when undefined, mode 11 behaves as
// mode 00 and the rotate path is not built.

module univ_shift_register #(
    parameter int N     = 11,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sclr,
    input  logic             load,
    input  logic [N-1:0]     data_in,
    input  logic             shift_s,
    input  logic             ser_in,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [N-1:0]     data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_BUSY = 1'b1;
    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);
    localparam logic [AMT_W-1:0] CNT_ZERO = '0;

    logic [0:0]       state;
    logic [N-1:0]     q;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       mode_l;
    logic             done_r;
    logic [1:0]       eff_mode;

    function automatic logic [N-1:0] step(input logic [N-1:0] v,
                                          input logic [1:0]   m,
                                          input logic         si);
        logic [N-1:0] r;
        r = v;
        case (m)
            2'b00: r = {v[N-2:0], si};
            2'b01: r = {si, v[N-1:1]};
            2'b10: r = {v[N-1], v[N-1:1]};
`ifdef USR_ROTATE_EN
            2'b11: r = {v[N-2:0], v[N-1]};
`else
            2'b11: r = {v[N-2:0], si};
`endif
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q      <= '0;
            state  <= ST_IDLE;
            cnt    <= CNT_ZERO;
            mode_l <= 2'b00;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == ST_BUSY) begin
                if (sclr) begin
                    // Abort: clear contents, no completion pulse.
                    q     <= '0;
                    state <= ST_IDLE;
                    cnt   <= CNT_ZERO;
                end else begin
                    q   <= step(q, mode_l, ser_in);
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state  <= ST_IDLE;
                        done_r <= 1'b1;
                    end
                end
            end else begin
                if (sclr) begin
                    q <= '0;
                end else if (load) begin
                    q <= data_in;
                end else if (start) begin
                    // Accepting edge only latches; first shift is on the next edge.
                    mode_l <= mode;
                    cnt    <= amount;
                    if (amount != CNT_ZERO) begin
                        state <= ST_BUSY;
                    end else begin
                        done_r <= 1'b1;
                    end
                end else if (shift_s) begin
                    q <= step(q, mode, ser_in);
                end
            end
        end
    end

    assign busy     = (state == ST_BUSY);
    assign done     = done_r;
    assign data_out = q;
    assign eff_mode = busy ? mode_l : mode;
    // Modes 00 and 11 move toward the MSB; 01 and 10 toward the LSB.
    assign ser_out  = (eff_mode == 2'b01 || eff_mode == 2'b10) ? q[0] : q[N-1];

endmodule

// File: tb/tb_univ_shift_register.sv
// tb/tb_univ_shift_register.sv - self-checking bench for univ_shift_register

module tb_univ_shift_register;

    localparam int N     = 11;
    localparam int AMT_W = 4;

    logic             clk;
    logic             clr;
    logic             sclr;
    logic             load;
    logic [N-1:0]     data_in;
    logic             shift_s;
    logic             ser_in;
    logic [1:0]       mode;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [N-1:0]     data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    int n_cmp;
    int n_err;
    logic [N-1:0] exp_q[$];

    univ_shift_register #(.N(N), .AMT_W(AMT_W)) dut (
        .clk(clk), .clr(clr), .sclr(sclr), .load(load), .data_in(data_in),
        .shift_s(shift_s), .ser_in(ser_in), .mode(mode), .start(start),
        .amount(amount), .data_out(data_out), .ser_out(ser_out),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference step built from explicit bit loops rather than concatenation.
    function automatic logic [N-1:0] model_step(input logic [N-1:0] v,
                                                input logic [1:0] m,
                                                input logic si);
        logic [N-1:0] r;
        logic rot;
`ifdef USR_ROTATE_EN
        rot = 1'b1;
`else
        rot = 1'b0;
`endif
        r = '0;
        if (m == 2'b00 || m == 2'b11) begin
            for (int i = N - 1; i > 0; i--) r[i] = v[i-1];
            r[0] = (m == 2'b11 && rot) ? v[N-1] : si;
        end else begin
            for (int i = 0; i < N - 1; i++) r[i] = v[i+1];
            r[N-1] = (m == 2'b10) ? v[N-1] : si;
        end
        return r;
    endfunction

    task automatic do_load(input logic [N-1:0] v);
        load = 1'b1;
        data_in = v;
        tick();
        load = 1'b0;
    endtask

    task automatic issue_start(input logic [1:0] m, input int a, input logic si);
        mode = m;
        amount = AMT_W'(a);
        ser_in = si;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge; waits for done and checks against the scoreboard.
    task automatic wait_and_check(input string name, input int a, input bit check_tail);
        int busy_cycles;
        int cycles;
        logic [N-1:0] expv;
        busy_cycles = 0;
        cycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cycles++;
            tick();
            cycles++;
        end
        expv = exp_q.pop_front();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: done=%b required 1", name, done);
        end
        n_cmp++;
        if (busy_cycles !== a) begin
            n_err++;
            $display("FAIL %s_busy_len: busy cycles=%0d required %0d", name, busy_cycles, a);
        end
        n_cmp++;
        if (data_out !== expv || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_result: data_out=%h busy=%b required %h busy=0", name, data_out, busy, expv);
        end
        if (check_tail) begin
            tick();
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL %s_done_pulse: done=%b required 0 one cycle later", name, done);
            end
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        #2;
        n_cmp++;
        if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset: data_out=%h busy=%b done=%b ser_out=%b required 0/0/0/0",
                     data_out, busy, done, ser_out);
        end
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_left_counted;
        do_load(11'h5A3);
        exp_q.push_back(11'h518);
        issue_start(2'b00, 3, 1'b0);
        wait_and_check("left3", 3, 1'b1);
    endtask

    task automatic test_arith_and_single;
        do_load(11'h400);
        exp_q.push_back(11'h700);
        issue_start(2'b10, 2, 1'b0);
        wait_and_check("arith2", 2, 1'b0);
        n_cmp++;
        if (ser_out !== 1'b0) begin
            n_err++;
            $display("FAIL arith2_ser_out: ser_out=%b required 0", ser_out);
        end
        tick();
        do_load(11'h000);
        mode = 2'b01;
        ser_in = 1'b1;
        shift_s = 1'b1;
        tick();
        shift_s = 1'b0;
        n_cmp++;
        if (data_out !== 11'h400) begin
            n_err++;
            $display("FAIL single_right: data_out=%h required 400", data_out);
        end
        n_cmp++;
        if (ser_out !== 1'b0) begin
            n_err++;
            $display("FAIL single_right_ser_out: ser_out=%b required 0", ser_out);
        end
    endtask

    task automatic test_rotate;
        do_load(11'h401);
`ifdef USR_ROTATE_EN
        exp_q.push_back(11'h003);
`else
        exp_q.push_back(11'h002);
`endif
        issue_start(2'b11, 1, 1'b0);
        wait_and_check("rot1", 1, 1'b1);
    endtask

    task automatic test_amount_zero;
        do_load(11'h123);
        issue_start(2'b00, 0, 1'b1);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || data_out !== 11'h123) begin
            n_err++;
            $display("FAIL amt0: done=%b busy=%b data_out=%h required 1/0/123", done, busy, data_out);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || data_out !== 11'h123) begin
            n_err++;
            $display("FAIL amt0_after: done=%b busy=%b data_out=%h required 0/0/123", done, busy, data_out);
        end
    endtask

    task automatic test_abort;
        int seen;
        // Asynchronous clear after the second shift.
        do_load(11'h0F0);
        issue_start(2'b00, 5, 1'b0);
        tick();
        tick();
        #2 clr = 1'b1;
        #1;
        n_cmp++;
        if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL clr_abort: data_out=%h busy=%b done=%b required 0/0/0", data_out, busy, done);
        end
        clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL clr_no_done: busy/done cycles=%0d required 0", seen);
        end
        // Synchronous clear after the second shift.
        do_load(11'h0F0);
        issue_start(2'b00, 5, 1'b0);
        tick();
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        n_cmp++;
        if (data_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL sclr_abort: data_out=%h busy=%b done=%b required 0/0/0", data_out, busy, done);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL sclr_no_done: busy/done cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        do_load(11'h5A3);
        exp_q.push_back(11'h518);
        issue_start(2'b00, 3, 1'b0);
        // Intrusions while busy, with live mode changed to check latching.
        mode = 2'b01;
        load = 1'b1;
        data_in = 11'h7FF;
        start = 1'b1;
        amount = 4'd7;
        n_cmp++;
        if (ser_out !== data_out[N-1]) begin
            n_err++;
            $display("FAIL busy_ser_out: ser_out=%b required %b", ser_out, data_out[N-1]);
        end
        cycles = 0;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
        end
        load = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || data_out !== exp_q.pop_front()) begin
            n_err++;
            $display("FAIL b2b_first: done=%b data_out=%h required 1/518", done, data_out);
        end
        // Start issued in the done cycle must be accepted.
        exp_q.push_back(11'h68C);
        issue_start(2'b01, 1, 1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b required 1", busy);
        end
        wait_and_check("b2b_second", 1, 1'b1);
    endtask

    task automatic test_random;
        logic [N-1:0] v;
        logic [N-1:0] e;
        logic [1:0] m;
        logic si;
        int a;
        for (int k = 0; k < 10; k++) begin
            v = N'($urandom);
            m = 2'($urandom_range(0, 3));
            si = 1'($urandom_range(0, 1));
            a = $urandom_range(1, 15);
            e = v;
            for (int s = 0; s < a; s++) e = model_step(e, m, si);
            do_load(v);
            exp_q.push_back(e);
            issue_start(m, a, si);
            wait_and_check("random", a, 1'b1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr = 1'b0;
        sclr = 1'b0;
        load = 1'b0;
        data_in = '0;
        shift_s = 1'b0;
        ser_in = 1'b0;
        mode = 2'b00;
        start = 1'b0;
        amount = '0;
        #1;
        test_reset();
        test_left_counted();
        test_arith_and_single();
        test_rotate();
        test_amount_zero();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
